// File: rtl/axi_slave_mem_pkg.sv
// Shared widths, AXI codes, FSM state types and the burst-legality helper
// used by both the write and read sides of the AXI slave memory.
package axi_slave_mem_pkg;

  localparam int ADDR_BITS  = 32;
  localparam int LEN_BITS   = 8;
  localparam int SIZE_BITS  = 3;
  localparam int DATA_BITS  = 32;
  localparam int STRB_BITS  = DATA_BITS / 8;
  localparam int BYTE_SHIFT = $clog2(STRB_BITS);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wr_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_t;

  // A burst is rejected for a wrong beat size, a reserved burst type or a
  // start word beyond the end of the memory.
  function automatic logic burst_error(input logic [ADDR_BITS-1:0] addr,
                                       input logic [SIZE_BITS-1:0] size,
                                       input logic [1:0]           burst,
                                       input int unsigned          depth);
    logic [ADDR_BITS-1:0] word;
    word = addr >> BYTE_SHIFT;
    return (size != SIZE_BITS'(BYTE_SHIFT)) ||
           ((burst != BURST_FIXED) && (burst != BURST_INCR)) ||
           (word >= ADDR_BITS'(depth));
  endfunction

endpackage

// File: rtl/axi_slave_rd.sv
// Read side: AR/R channel FSM. The next beat is loaded into the R
// registers on the edge that consumes the current one, giving one beat per
// cycle under continuous r_ready.
module axi_slave_rd import axi_slave_mem_pkg::*; #(
  parameter int MEM_DEPTH = 256,
  localparam int IDX_BITS = $clog2(MEM_DEPTH)
) (
  input  logic                 aclk,
  input  logic                 areset_n,
  input  logic [ADDR_BITS-1:0] ar_addr,
  input  logic [LEN_BITS-1:0]  ar_len,
  input  logic [SIZE_BITS-1:0] ar_size,
  input  logic [1:0]           ar_burst,
  input  logic                 ar_valid,
  output logic                 ar_ready,
  output logic [DATA_BITS-1:0] r_data,
  output logic [1:0]           r_resp,
  output logic                 r_last,
  output logic                 r_valid,
  input  logic                 r_ready,
  output logic [IDX_BITS-1:0]  mem_idx,
  input  logic [DATA_BITS-1:0] mem_rdata,
  output logic                 state
);

  rd_state_t             state_q, state_n;
  logic [IDX_BITS-1:0]   idx, idx_n, step_idx;
  logic [LEN_BITS-1:0]   len, len_n, cnt, cnt_n;
  logic [1:0]            burst, burst_n, r_resp_n;
  logic                  err, err_n, r_last_n;
  logic [DATA_BITS-1:0]  r_data_n;

  assign state = state_q;

  // Next-state logic; mem_idx addresses the word to be presented next.
  always_comb begin
    state_n  = state_q;
    idx_n    = idx;
    len_n    = len;
    burst_n  = burst;
    cnt_n    = cnt;
    err_n    = err;
    r_data_n = r_data;
    r_resp_n = r_resp;
    r_last_n = r_last;
    step_idx = (burst == BURST_INCR) ? idx + IDX_BITS'(1) : idx;
    mem_idx  = step_idx;
    case (state_q)
      R_IDLE: begin
        mem_idx = ar_addr[IDX_BITS+BYTE_SHIFT-1:BYTE_SHIFT];
        if (ar_valid && ar_ready) begin
          err_n    = burst_error(ar_addr, ar_size, ar_burst, MEM_DEPTH);
          idx_n    = mem_idx;
          len_n    = ar_len;
          burst_n  = ar_burst;
          cnt_n    = '0;
          r_data_n = err_n ? '0 : mem_rdata;
          r_resp_n = err_n ? RESP_SLVERR : RESP_OKAY;
          r_last_n = (ar_len == '0);
          state_n  = R_DATA;
        end
      end
      R_DATA: begin
        if (r_valid && r_ready) begin
          if (r_last) begin
            state_n = R_IDLE;
          end else begin
            cnt_n    = cnt + LEN_BITS'(1);
            idx_n    = step_idx;
            r_data_n = err ? '0 : mem_rdata;
            r_last_n = (cnt_n == len);
          end
        end
      end
      default: state_n = R_IDLE;
    endcase
  end

  // State and registered R channel; r_valid is high exactly in R_DATA.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      state_q  <= R_IDLE;
      idx      <= '0;
      len      <= '0;
      burst    <= BURST_FIXED;
      cnt      <= '0;
      err      <= 1'b0;
      ar_ready <= 1'b0;
      r_valid  <= 1'b0;
      r_data   <= '0;
      r_resp   <= RESP_OKAY;
      r_last   <= 1'b0;
    end else begin
      state_q  <= state_n;
      idx      <= idx_n;
      len      <= len_n;
      burst    <= burst_n;
      cnt      <= cnt_n;
      err      <= err_n;
      ar_ready <= (state_n == R_IDLE);
      r_valid  <= (state_n == R_DATA);
      r_data   <= r_data_n;
      r_resp   <= r_resp_n;
      r_last   <= r_last_n;
    end
  end

endmodule

// File: rtl/axi_slave_wr.sv
// Write side: AW/W/B channel FSM and the memory write port.
// Handshake rule on every channel: a transfer happens on the rising edge
// where valid && ready are both high; once raised, a responder output is
// held stable until its handshake completes.
module axi_slave_wr import axi_slave_mem_pkg::*; #(
  parameter int MEM_DEPTH = 256,
  localparam int IDX_BITS = $clog2(MEM_DEPTH)
) (
  input  logic                 aclk,
  input  logic                 areset_n,
  input  logic [ADDR_BITS-1:0] aw_addr,
  input  logic [LEN_BITS-1:0]  aw_len,
  input  logic [SIZE_BITS-1:0] aw_size,
  input  logic [1:0]           aw_burst,
  input  logic                 aw_valid,
  output logic                 aw_ready,
  input  logic [DATA_BITS-1:0] w_data,
  input  logic [STRB_BITS-1:0] w_strb,
  input  logic                 w_last,
  input  logic                 w_valid,
  output logic                 w_ready,
  output logic [1:0]           b_resp,
  output logic                 b_valid,
  input  logic                 b_ready,
  output logic                 mem_we,
  output logic [IDX_BITS-1:0]  mem_idx,
  output logic [DATA_BITS-1:0] mem_wdata,
  output logic [STRB_BITS-1:0] mem_wstrb,
  output logic [1:0]           state
);

  wr_state_t             state_q, state_n;
  logic [IDX_BITS-1:0]   idx, idx_n;
  logic [LEN_BITS-1:0]   len, len_n, cnt, cnt_n;
  logic [1:0]            burst, burst_n, b_resp_n;
  logic                  cfg_err, cfg_err_n, last_err, last_err_n;
  logic                  beat_last, last_bad;

  assign mem_idx   = idx;
  assign mem_wdata = w_data;
  assign mem_wstrb = w_strb;
  assign state     = state_q;

  // Next-state and next-register logic; the burst ends on the beat count,
  // a w_last that disagrees with it only poisons the response.
  always_comb begin
    state_n    = state_q;
    idx_n      = idx;
    len_n      = len;
    burst_n    = burst;
    cnt_n      = cnt;
    cfg_err_n  = cfg_err;
    last_err_n = last_err;
    b_resp_n   = b_resp;
    mem_we     = 1'b0;
    beat_last  = (cnt == len);
    last_bad   = (w_last != beat_last);
    case (state_q)
      W_IDLE: begin
        if (aw_valid && aw_ready) begin
          idx_n      = aw_addr[IDX_BITS+BYTE_SHIFT-1:BYTE_SHIFT];
          len_n      = aw_len;
          burst_n    = aw_burst;
          cnt_n      = '0;
          cfg_err_n  = burst_error(aw_addr, aw_size, aw_burst, MEM_DEPTH);
          last_err_n = 1'b0;
          state_n    = W_DATA;
        end
      end
      W_DATA: begin
        if (w_valid && w_ready) begin
          mem_we = !cfg_err;
          if (last_bad) last_err_n = 1'b1;
          if (beat_last) begin
            b_resp_n = (cfg_err || last_err || last_bad) ? RESP_SLVERR : RESP_OKAY;
            state_n  = W_RESP;
          end else begin
            cnt_n = cnt + LEN_BITS'(1);
            if (burst == BURST_INCR) idx_n = idx + IDX_BITS'(1);
          end
        end
      end
      W_RESP: begin
        if (b_valid && b_ready) state_n = W_IDLE;
      end
      default: state_n = W_IDLE;
    endcase
  end

  // State and registered channel outputs; ready/valid follow the next state.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      state_q  <= W_IDLE;
      idx      <= '0;
      len      <= '0;
      burst    <= BURST_FIXED;
      cnt      <= '0;
      cfg_err  <= 1'b0;
      last_err <= 1'b0;
      aw_ready <= 1'b0;
      w_ready  <= 1'b0;
      b_valid  <= 1'b0;
      b_resp   <= RESP_OKAY;
    end else begin
      state_q  <= state_n;
      idx      <= idx_n;
      len      <= len_n;
      burst    <= burst_n;
      cnt      <= cnt_n;
      cfg_err  <= cfg_err_n;
      last_err <= last_err_n;
      aw_ready <= (state_n == W_IDLE);
      w_ready  <= (state_n == W_DATA);
      b_valid  <= (state_n == W_RESP);
      b_resp   <= b_resp_n;
    end
  end

endmodule

// File: rtl/axi_slave_mem.sv
// AXI slave memory: shared word array with independent write and read FSMs.
// A read load and a write on the same edge see the pre-write contents.
module axi_slave_mem import axi_slave_mem_pkg::*; #(
  parameter int MEM_DEPTH = 256
) (
  input  logic                 aclk,
  input  logic                 areset_n,
  input  logic [ADDR_BITS-1:0] aw_addr,
  input  logic [LEN_BITS-1:0]  aw_len,
  input  logic [SIZE_BITS-1:0] aw_size,
  input  logic [1:0]           aw_burst,
  input  logic [3:0]           aw_cache,
  input  logic                 aw_valid,
  output logic                 aw_ready,
  input  logic [DATA_BITS-1:0] w_data,
  input  logic [STRB_BITS-1:0] w_strb,
  input  logic                 w_last,
  input  logic                 w_valid,
  output logic                 w_ready,
  output logic [1:0]           b_resp,
  output logic                 b_valid,
  input  logic                 b_ready,
  input  logic [ADDR_BITS-1:0] ar_addr,
  input  logic [LEN_BITS-1:0]  ar_len,
  input  logic [SIZE_BITS-1:0] ar_size,
  input  logic [1:0]           ar_burst,
  input  logic [3:0]           ar_cache,
  input  logic                 ar_valid,
  output logic                 ar_ready,
  output logic [DATA_BITS-1:0] r_data,
  output logic [1:0]           r_resp,
  output logic                 r_last,
  output logic                 r_valid,
  input  logic                 r_ready,
  output logic [1:0]           wr_state,
  output logic                 rd_state
);

  localparam int IDX_BITS = $clog2(MEM_DEPTH);

  logic [DATA_BITS-1:0] mem [MEM_DEPTH];
  logic                 wr_we;
  logic [IDX_BITS-1:0]  wr_idx, rd_idx;
  logic [DATA_BITS-1:0] wr_wdata, rd_rdata;
  logic [STRB_BITS-1:0] wr_wstrb;
  logic                 unused_cache;

  // Cache attributes carry no meaning for a plain RAM.
  assign unused_cache = ^{aw_cache, ar_cache};
  assign rd_rdata     = mem[rd_idx];

  axi_slave_wr #(.MEM_DEPTH(MEM_DEPTH)) u_wr (
    .aclk(aclk), .areset_n(areset_n),
    .aw_addr(aw_addr), .aw_len(aw_len), .aw_size(aw_size), .aw_burst(aw_burst),
    .aw_valid(aw_valid), .aw_ready(aw_ready),
    .w_data(w_data), .w_strb(w_strb), .w_last(w_last), .w_valid(w_valid), .w_ready(w_ready),
    .b_resp(b_resp), .b_valid(b_valid), .b_ready(b_ready),
    .mem_we(wr_we), .mem_idx(wr_idx), .mem_wdata(wr_wdata), .mem_wstrb(wr_wstrb),
    .state(wr_state)
  );

  axi_slave_rd #(.MEM_DEPTH(MEM_DEPTH)) u_rd (
    .aclk(aclk), .areset_n(areset_n),
    .ar_addr(ar_addr), .ar_len(ar_len), .ar_size(ar_size), .ar_burst(ar_burst),
    .ar_valid(ar_valid), .ar_ready(ar_ready),
    .r_data(r_data), .r_resp(r_resp), .r_last(r_last), .r_valid(r_valid), .r_ready(r_ready),
    .mem_idx(rd_idx), .mem_rdata(rd_rdata),
    .state(rd_state)
  );

  // Byte-enabled write port; contents survive reset.
  always_ff @(posedge aclk) begin
    if (wr_we) begin
      for (int i = 0; i < STRB_BITS; i++) begin
        if (wr_wstrb[i]) mem[wr_idx][8*i +: 8] <= wr_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi_slave_mem.sv
// Bench for axi_slave_mem: directed steps plus a randomized section, all
// checked against a word-array reference model of the memory.
module tb_axi_slave_mem;
  import axi_slave_mem_pkg::*;

  logic        aclk = 1'b0;
  logic        areset_n;
  logic [31:0] aw_addr, ar_addr, w_data;
  logic [7:0]  aw_len, ar_len;
  logic [2:0]  aw_size, ar_size;
  logic [1:0]  aw_burst, ar_burst;
  logic [3:0]  aw_cache, ar_cache, w_strb;
  logic        aw_valid, w_last, w_valid, b_ready, ar_valid, r_ready;
  logic        aw_ready, w_ready, b_valid, ar_ready, r_last, r_valid;
  logic [1:0]  b_resp, r_resp;
  logic [31:0] r_data;
  logic [1:0]  wr_state;
  logic        rd_state;

  axi_slave_mem #(.MEM_DEPTH(256)) dut (
    .aclk(aclk), .areset_n(areset_n),
    .aw_addr(aw_addr), .aw_len(aw_len), .aw_size(aw_size), .aw_burst(aw_burst),
    .aw_cache(aw_cache), .aw_valid(aw_valid), .aw_ready(aw_ready),
    .w_data(w_data), .w_strb(w_strb), .w_last(w_last), .w_valid(w_valid), .w_ready(w_ready),
    .b_resp(b_resp), .b_valid(b_valid), .b_ready(b_ready),
    .ar_addr(ar_addr), .ar_len(ar_len), .ar_size(ar_size), .ar_burst(ar_burst),
    .ar_cache(ar_cache), .ar_valid(ar_valid), .ar_ready(ar_ready),
    .r_data(r_data), .r_resp(r_resp), .r_last(r_last), .r_valid(r_valid), .r_ready(r_ready),
    .wr_state(wr_state), .rd_state(rd_state)
  );

  // ---------------- clock ----------------
  always #5 aclk = ~aclk;

  // ---------------- reference model / scoreboard ----------------
  logic [31:0] mem_m [256];
  logic [31:0] wdata_a [256];
  logic [3:0]  wstrb_a [256];
  logic [31:0] exp_q [$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          pat [4]  = '{1, 0, 0, 1};

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    assert (got === expv) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, expv);
  endtask

  function automatic bit cfg_bad(input logic [31:0] addr, input logic [2:0] size,
                                 input logic [1:0] burst);
    return (size != 3'd2) || (burst > 2'd1) || ((addr >> 2) >= 32'd256);
  endfunction

  // Applies a write burst to the model; returns the expected B response.
  function automatic logic [1:0] model_write(input logic [31:0] addr, input int len,
                                             input logic [1:0] burst, input logic [2:0] size,
                                             input int early);
    int base, idx;
    bit err;
    err  = cfg_bad(addr, size, burst);
    base = int'((addr >> 2) % 256);
    if (!err) begin
      for (int b = 0; b <= len; b++) begin
        idx = (burst == BURST_FIXED) ? base : (base + b) % 256;
        for (int k = 0; k < 4; k++)
          if (wstrb_a[b][k]) mem_m[idx][8*k +: 8] = wdata_a[b][8*k +: 8];
      end
    end
    return (err || (early >= 0 && early < len)) ? 2'b10 : 2'b00;
  endfunction

  // Fills exp_q with the beats a read burst must return; returns its response.
  function automatic logic [1:0] model_read(input logic [31:0] addr, input int len,
                                            input logic [1:0] burst, input logic [2:0] size);
    int base, idx;
    bit err;
    err  = cfg_bad(addr, size, burst);
    base = int'((addr >> 2) % 256);
    exp_q.delete();
    for (int b = 0; b <= len; b++) begin
      idx = (burst == BURST_FIXED) ? base : (base + b) % 256;
      exp_q.push_back(err ? 32'h0 : mem_m[idx]);
    end
    return err ? 2'b10 : 2'b00;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_write(input logic [31:0] addr, input int len, input logic [1:0] burst,
                          input logic [2:0] size, input int early, input string tag);
    logic [1:0] exp_resp;
    int w;
    exp_resp = model_write(addr, len, burst, size, early);
    aw_addr = addr; aw_len = 8'(len); aw_size = size; aw_burst = burst; aw_valid = 1'b1;
    w = 0;
    while (!aw_ready && w < 100) begin tick(); w++; end
    check({tag, "_aw_ready"}, 32'(aw_ready), 32'd1);
    tick();
    aw_valid = 1'b0;
    for (int b = 0; b <= len; b++) begin
      w_data = wdata_a[b]; w_strb = wstrb_a[b];
      w_last = (b == len) || (b == early); w_valid = 1'b1;
      w = 0;
      while (!w_ready && w < 100) begin tick(); w++; end
      if (!w_ready) check({tag, "_w_ready"}, 32'(w_ready), 32'd1);
      tick();
    end
    w_valid = 1'b0; w_last = 1'b0;
    check({tag, "_b_valid_latency"}, 32'(b_valid), 32'd1);
    check({tag, "_b_resp"}, 32'(b_resp), 32'(exp_resp));
    b_ready = 1'b1;
    tick();
    b_ready = 1'b0;
    check({tag, "_b_valid_drop"}, 32'(b_valid), 32'd0);
  endtask

  task automatic do_read(input logic [31:0] addr, input int len, input logic [1:0] burst,
                         input logic [2:0] size, input bit stall, input string tag);
    logic [1:0] exp_resp;
    logic [31:0] dmy;
    int w, beat, cyc;
    exp_resp = model_read(addr, len, burst, size);
    ar_addr = addr; ar_len = 8'(len); ar_size = size; ar_burst = burst; ar_valid = 1'b1;
    w = 0;
    while (!ar_ready && w < 100) begin tick(); w++; end
    check({tag, "_ar_ready"}, 32'(ar_ready), 32'd1);
    tick();
    ar_valid = 1'b0;
    check({tag, "_r_valid_latency"}, 32'(r_valid), 32'd1);
    beat = 0; cyc = 0;
    while (beat <= len && cyc < 1200) begin
      r_ready = stall ? (pat[cyc % 4] != 0) : 1'b1;
      if (r_valid) begin
        check($sformatf("%s_rdata_b%0d", tag, beat), r_data, exp_q[0]);
        check($sformatf("%s_rlast_b%0d", tag, beat), 32'(r_last), 32'(beat == len));
        check($sformatf("%s_rresp_b%0d", tag, beat), 32'(r_resp), 32'(exp_resp));
        if (r_ready) begin beat++; dmy = exp_q.pop_front(); end
      end
      tick();
      cyc++;
    end
    r_ready = 1'b0;
    check({tag, "_beats"}, 32'(beat), 32'(len + 1));
    check({tag, "_r_valid_end"}, 32'(r_valid), 32'd0);
    if (!stall) check({tag, "_throughput"}, 32'(cyc), 32'(len + 1));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed and random sequence ----------------
  initial begin
    int          len_r;
    logic [1:0]  bt_r;
    logic [31:0] a_r, old_v, new_v;
    int          w;

    areset_n = 1'b0;
    aw_addr = '0; aw_len = '0; aw_size = 3'd2; aw_burst = BURST_INCR; aw_cache = '0; aw_valid = 1'b0;
    w_data = '0; w_strb = '0; w_last = 1'b0; w_valid = 1'b0; b_ready = 1'b0;
    ar_addr = '0; ar_len = '0; ar_size = 3'd2; ar_burst = BURST_INCR; ar_cache = '0; ar_valid = 1'b0;
    r_ready = 1'b0;
    for (int i = 0; i < 256; i++) mem_m[i] = '0;

    // Reset state
    tick(); tick(); tick();
    check("rst_ctrl", 32'({aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_resp, r_last}), 32'd0);
    check("rst_rdata", r_data, 32'd0);
    areset_n = 1'b1;
    check("rst_aw_ready_hold", 32'(aw_ready), 32'd0);
    tick();
    check("rst_aw_ready_rise", 32'(aw_ready), 32'd1);
    check("rst_ar_ready_rise", 32'(ar_ready), 32'd1);
    check("rst_wr_state", 32'(wr_state), 32'(W_IDLE));
    check("rst_rd_state", 32'(rd_state), 32'(R_IDLE));

    // Fill the whole memory with a 256-beat INCR burst, then read it back
    for (int b = 0; b < 256; b++) begin wdata_a[b] = $urandom; wstrb_a[b] = 4'hF; end
    do_write(32'h0, 255, BURST_INCR, 3'd2, -1, "fill_wr");
    do_read(32'h0, 255, BURST_INCR, 3'd2, 1'b0, "fill_rd");

    // INCR write/read at 0x10
    for (int b = 0; b < 4; b++) begin wdata_a[b] = 32'hA0 + 32'(b); wstrb_a[b] = 4'hF; end
    do_write(32'h10, 3, BURST_INCR, 3'd2, -1, "incr_wr");
    do_read(32'h10, 3, BURST_INCR, 3'd2, 1'b0, "incr_rd");

    // Byte strobes with a FIXED burst
    wdata_a[0] = 32'hFFFF_FFFF; wstrb_a[0] = 4'hF;
    do_write(32'h20, 0, BURST_INCR, 3'd2, -1, "pre_wr");
    wdata_a[0] = 32'h0000_0011; wstrb_a[0] = 4'b0001;
    wdata_a[1] = 32'h0000_2200; wstrb_a[1] = 4'b0100;
    do_write(32'h20, 1, BURST_FIXED, 3'd2, -1, "fixed_wr");
    do_read(32'h20, 0, BURST_INCR, 3'd2, 1'b0, "fixed_rd");
    do_read(32'h20, 2, BURST_FIXED, 3'd2, 1'b0, "fixed_rd3");

    // Backpressure, then continuous ready
    do_read(32'h10, 3, BURST_INCR, 3'd2, 1'b1, "bp_rd");
    do_read(32'h10, 3, BURST_INCR, 3'd2, 1'b0, "bp_rd_cont");

    // Error cases
    for (int b = 0; b < 4; b++) begin wdata_a[b] = $urandom; wstrb_a[b] = 4'hF; end
    do_write(32'h40, 3, 2'b10, 3'd2, -1, "err_burst_wr");
    do_read(32'h40, 3, BURST_INCR, 3'd2, 1'b0, "err_burst_chk");
    do_write(32'h60, 1, BURST_INCR, 3'd1, -1, "err_size_wr");
    do_read(32'h400, 2, BURST_INCR, 3'd2, 1'b0, "err_oor_rd");
    do_read(32'h30, 1, 2'b11, 3'd2, 1'b1, "err_type_rd");
    do_write(32'h50, 3, BURST_INCR, 3'd2, 1, "err_last_wr");

    // Same-edge write and read of idx 5
    old_v = mem_m[5];
    new_v = $urandom;
    aw_addr = 32'h14; aw_len = 8'd0; aw_size = 3'd2; aw_burst = BURST_INCR; aw_valid = 1'b1;
    w = 0;
    while (!aw_ready && w < 100) begin tick(); w++; end
    tick();
    aw_valid = 1'b0;
    w_data = new_v; w_strb = 4'hF; w_last = 1'b1; w_valid = 1'b1;
    ar_addr = 32'h14; ar_len = 8'd0; ar_size = 3'd2; ar_burst = BURST_INCR; ar_valid = 1'b1;
    check("conc_w_ready", 32'(w_ready), 32'd1);
    check("conc_ar_ready", 32'(ar_ready), 32'd1);
    tick();
    w_valid = 1'b0; w_last = 1'b0; ar_valid = 1'b0;
    check("conc_r_valid", 32'(r_valid), 32'd1);
    check("conc_old_data", r_data, old_v);
    check("conc_b_valid", 32'(b_valid), 32'd1);
    check("conc_b_resp", 32'(b_resp), 32'd0);
    r_ready = 1'b1; b_ready = 1'b1;
    tick();
    r_ready = 1'b0; b_ready = 1'b0;
    mem_m[5] = new_v;
    do_read(32'h14, 0, BURST_INCR, 3'd2, 1'b0, "conc_new_rd");

    // Reset in the middle of a write burst at idx 64
    aw_addr = 32'h100; aw_len = 8'd3; aw_size = 3'd2; aw_burst = BURST_INCR; aw_valid = 1'b1;
    w = 0;
    while (!aw_ready && w < 100) begin tick(); w++; end
    tick();
    aw_valid = 1'b0;
    for (int b = 0; b < 2; b++) begin
      new_v = $urandom;
      w_data = new_v; w_strb = 4'hF; w_last = 1'b0; w_valid = 1'b1;
      w = 0;
      while (!w_ready && w < 100) begin tick(); w++; end
      tick();
      mem_m[64 + b] = new_v;
    end
    w_data = $urandom;
    #2 areset_n = 1'b0;
    #1;
    check("midrst_ctrl", 32'({aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_resp, r_last}), 32'd0);
    check("midrst_rdata", r_data, 32'd0);
    w_valid = 1'b0;
    tick(); tick();
    areset_n = 1'b1;
    tick();
    check("midrst_aw_ready", 32'(aw_ready), 32'd1);
    check("midrst_no_b", 32'(b_valid), 32'd0);
    tick();
    check("midrst_no_b2", 32'(b_valid), 32'd0);
    do_read(32'h100, 3, BURST_INCR, 3'd2, 1'b0, "midrst_rd");
    for (int b = 0; b < 2; b++) begin wdata_a[b] = $urandom; wstrb_a[b] = 4'hF; end
    do_write(32'h100, 1, BURST_INCR, 3'd2, -1, "midrst_wr");
    do_read(32'h100, 1, BURST_INCR, 3'd2, 1'b1, "midrst_rd2");

    // Randomized bursts in the upper half of memory
    for (int it = 0; it < 12; it++) begin
      len_r = $urandom_range(0, 15);
      bt_r  = ($urandom_range(0, 1) == 1) ? BURST_INCR : BURST_FIXED;
      a_r   = 32'($urandom_range(128, 255)) << 2;
      if ($urandom_range(0, 1) == 1) begin
        for (int b = 0; b <= len_r; b++) begin
          wdata_a[b] = $urandom;
          wstrb_a[b] = 4'($urandom_range(0, 15));
        end
        do_write(a_r, len_r, bt_r, 3'd2, -1, $sformatf("rnd%0d_wr", it));
      end else begin
        do_read(a_r, len_r, bt_r, 3'd2, 1'($urandom_range(0, 1)), $sformatf("rnd%0d_rd", it));
      end
    end

    // INCR wrap from idx 254 through 0
    for (int b = 0; b < 4; b++) begin wdata_a[b] = $urandom; wstrb_a[b] = 4'hF; end
    do_write(32'h3F8, 3, BURST_INCR, 3'd2, -1, "wrap_wr");
    do_read(32'h3F8, 3, BURST_INCR, 3'd2, 1'b0, "wrap_rd");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
